// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 800x600@60 Hz (40 MHz pixel clock) timing constants,
// the colour-bar palette and small helpers shared by the timing generator,
// the draw stages and benches.
package vga_timing_pkg;

    localparam int CNT_W = 12;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 128;
    localparam int H_BP_DEF     = 88;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FP_DEF     = 1;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BP_DEF     = 23;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Eight vertical bars, left to right.
    localparam int BAR_COUNT = 8;
    localparam logic [11:0] BAR_COLORS [BAR_COUNT] = '{
        12'hfff, 12'hff0, 12'h0ff, 12'h0f0,
        12'hf0f, 12'hf00, 12'h00f, 12'h000
    };

    // Registered per-pixel control flags that travel with the counters.
    typedef struct packed {
        logic hsync;
        logic hblnk;
        logic vsync;
        logic vblnk;
        logic frame_start;
    } vga_ctl_t;

    // True when val lies in [lo, lo+len-1].
    function automatic logic in_window(logic [CNT_W-1:0] val, int lo, int len);
        return (int'(val) >= lo) && (int'(val) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-timing stream between the generator (master) and the
// overlay stages (slave). The consumer side owns the pixel enable.
interface vga_timing_if;
    logic        en;
    logic [11:0] hcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic [11:0] vcount_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic        frame_start;
    logic [11:0] rgb_out;

    modport master (
        input  en,
        output hcount_out, hsync_out, hblnk_out,
        output vcount_out, vsync_out, vblnk_out,
        output frame_start, rgb_out
    );

    modport slave (
        output en,
        input  hcount_out, hsync_out, hblnk_out,
        input  vcount_out, vsync_out, vblnk_out,
        input  frame_start, rgb_out
    );
endinterface

// File: rtl/vga_mod_counter.sv
// vga_mod_counter: modulo-N counter with enable, async active-low reset.
// Exposes both the registered count and its next value so that callers can
// register derived flags in the same cycle as the count itself.
module vga_mod_counter #(
    parameter int N = 1056,
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_d_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Wrap is qualified by the enable so it can chain the next counter directly.
    assign wrap_o = en_i && (count_q == LAST);

    // Next count: hold, increment, or wrap to zero after N-1.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@60 Hz VGA timing source (hcount/vcount, syncs,
// blanking, frame strobe). All outputs are registered and mutually aligned.
// Optional feature macro: VGA_TIMING_TEST_PATTERN_EN (8 colour bars on rgb_out);
// without it rgb_out is constant 12'h000.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic         clk_in,
    input  logic         rst_n,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are fixed at 12 bits; larger totals cannot be represented.
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 4095");
    end

    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] h_d;
    logic [CNT_W-1:0] v_q;
    logic [CNT_W-1:0] v_d;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_en;

    // The vertical counter steps once per completed line.
    assign v_en = vga.en & h_wrap;

    vga_mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
        .clk_i     (clk_in),
        .rst_ni    (rst_n),
        .en_i      (vga.en),
        .count_o   (h_q),
        .count_d_o (h_d),
        .wrap_o    (h_wrap)
    );

    vga_mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
        .clk_i     (clk_in),
        .rst_ni    (rst_n),
        .en_i      (v_en),
        .count_o   (v_q),
        .count_d_o (v_d),
        .wrap_o    (v_wrap)
    );

    vga_ctl_t ctl_d;
    vga_ctl_t ctl_q;

    // Flags derived from the next counter values so they land with the counts.
    // With en low the next values equal the current ones, so flags hold, while
    // frame_start drops because v_wrap is enable-qualified.
    always_comb begin
        ctl_d             = '0;
        ctl_d.hblnk       = (h_d >= CNT_W'(H_ACTIVE));
        ctl_d.vblnk       = (v_d >= CNT_W'(V_ACTIVE));
        ctl_d.hsync       = in_window(h_d, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
        ctl_d.vsync       = in_window(v_d, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
        ctl_d.frame_start = v_wrap;
    end

    // Control flag register; syncs idle at the inactive level in reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q <= '{hsync: ~SYNC_POL, hblnk: 1'b0, vsync: ~SYNC_POL,
                       vblnk: 1'b0, frame_start: 1'b0};
        end else begin
            ctl_q <= ctl_d;
        end
    end

    assign vga.hcount_out  = h_q;
    assign vga.vcount_out  = v_q;
    assign vga.hsync_out   = ctl_q.hsync;
    assign vga.hblnk_out   = ctl_q.hblnk;
    assign vga.vsync_out   = ctl_q.vsync;
    assign vga.vblnk_out   = ctl_q.vblnk;
    assign vga.frame_start = ctl_q.frame_start;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / BAR_COUNT;

    logic [2:0]  bar_sel;
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;

    // Bar colour for the next pixel, black during any blanking.
    always_comb begin
        bar_sel = 3'(h_d / CNT_W'(BAR_W));
        rgb_d   = (ctl_d.hblnk || ctl_d.vblnk) ? 12'h000 : BAR_COLORS[bar_sel];
    end

    // Colour register, aligned with the counters.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vga.rgb_out = rgb_q;
`else
    assign vga.rgb_out = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-enable bench for vga_timing_gen. Two instances:
// the default 800x600 timing, and a tiny timing (24x10, active-low syncs) so
// that whole frames, vsync and frame_start fit in a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vga_timing_if ifa ();
    vga_timing_if ifb ();

    vga_timing_gen dut_a (
        .clk_in (clk),
        .rst_n  (rst_n),
        .vga    (ifa)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b0)
    ) dut_b (
        .clk_in (clk),
        .rst_n  (rst_n),
        .vga    (ifb)
    );

    int total = 0;
    int bad   = 0;

    logic [11:0] bars [8] = '{12'hfff, 12'hff0, 12'h0ff, 12'h0f0,
                              12'hf0f, 12'hf00, 12'h00f, 12'h000};

    // Reference state: number of en-qualified clocks since reset, and whether
    // the most recent clock landed on (0,0) with en high.
    longint ka, kb;
    bit     fsa, fsb;

    localparam longint FRAME_A = 1056 * 628;
    localparam longint FRAME_B = 24 * 10;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(
        input string p, input longint k, input bit fs,
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb, input bit pol,
        input logic [11:0] hc, input logic hsy, input logic hbl,
        input logic [11:0] vc, input logic vsy, input logic vbl,
        input logic fst, input logic [11:0] rgb);
        longint ht, vt, h, v;
        logic [11:0] exp_rgb;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h  = k % ht;
        v  = (k / ht) % vt;
        chk({p, ".hcount"}, 32'(hc), 32'(h));
        chk({p, ".vcount"}, 32'(vc), 32'(v));
        chk({p, ".hblnk"},  32'(hbl), 32'(h >= ha));
        chk({p, ".vblnk"},  32'(vbl), 32'(v >= va));
        chk({p, ".hsync"},  32'(hsy), 32'((h >= ha + hf && h < ha + hf + hs) ? pol : !pol));
        chk({p, ".vsync"},  32'(vsy), 32'((v >= va + vf && v < va + vf + vs) ? pol : !pol));
        chk({p, ".frame_start"}, 32'(fst), 32'(fs));
        exp_rgb = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        if (h < ha && v < va) exp_rgb = bars[h / (ha / 8)];
`endif
        chk({p, ".rgb"}, 32'(rgb), 32'(exp_rgb));
    endtask

    task automatic check_all();
        check_inst("a", ka, fsa, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1,
                   ifa.hcount_out, ifa.hsync_out, ifa.hblnk_out,
                   ifa.vcount_out, ifa.vsync_out, ifa.vblnk_out,
                   ifa.frame_start, ifa.rgb_out);
        check_inst("b", kb, fsb, 16, 2, 3, 3, 6, 1, 2, 1, 1'b0,
                   ifb.hcount_out, ifb.hsync_out, ifb.hblnk_out,
                   ifb.vcount_out, ifb.vsync_out, ifb.vblnk_out,
                   ifb.frame_start, ifb.rgb_out);
    endtask

    // One clock: drive enables, advance the reference, sample 1 time unit later.
    task automatic step(input bit ea, input bit eb);
        ifa.en = ea;
        ifb.en = eb;
        @(posedge clk);
        if (ea) begin ka++; fsa = (ka % FRAME_A == 0); end else fsa = 1'b0;
        if (eb) begin kb++; fsb = (kb % FRAME_B == 0); end else fsb = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        int hs_cnt_a, vs_cnt_b, first_fs_b, fs_cnt_b, guard;
        hs_cnt_a = 0; vs_cnt_b = 0; first_fs_b = -1; fs_cnt_b = 0;
        ka = 0; kb = 0; fsa = 0; fsb = 0;
        rst_n = 1'b0;
        ifa.en = 1'b0;
        ifb.en = 1'b0;

        // Reset held across several edges.
        repeat (3) @(posedge clk);
        #1 check_all();

        // Release between edges: output is (0,0) immediately.
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();

        // Continuous run: one full line of A, several frames of B.
        for (int i = 0; i < 1200; i++) begin
            step(1'b1, 1'b1);
            if (ka <= 1056 && ifa.hsync_out) hs_cnt_a++;
            if (kb <= FRAME_B && !ifb.vsync_out) vs_cnt_b++;
            if (ifb.frame_start) begin
                fs_cnt_b++;
                if (first_fs_b < 0) first_fs_b = int'(kb);
            end
        end
        chk("a.hsync_width", 32'(hs_cnt_a), 32'd128);
        chk("b.vsync_cycles", 32'(vs_cnt_b), 32'(2 * 24));
        chk("b.first_frame_start", 32'(first_fs_b), 32'(FRAME_B));
        chk("b.frame_start_count", 32'(fs_cnt_b), 32'(1200 / FRAME_B));

        // Freeze A at hcount 500 for 50 clocks, then resume.
        guard = 0;
        while ((ka % 1056) != 500 && guard < 2000) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("a.reach_h500", 32'(ka % 1056), 32'd500);
        for (int i = 0; i < 50; i++) step(1'b0, 1'($urandom_range(0, 1)));
        chk("a.frozen_h", 32'(ifa.hcount_out), 32'd500);
        for (int i = 0; i < 700; i++) step(1'b1, 1'b1);

        // Random enable pattern.
        for (int i = 0; i < 15000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges, mid-line / mid-frame.
        #2 rst_n = 1'b0;
        ka = 0; kb = 0; fsa = 0; fsb = 0;
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
